// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: host bytes queue in a small FIFO and are framed
// as start, 8 data bits LSB first, optional even parity, stop.
module uart_tx_buffered #(
    parameter int DEPTH       = 8,
    parameter int CLK_PER_BIT = 5208
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [12:0]              clk_per_bit,
    input  logic                     parity_en,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     tx,
    output logic                     busy,
    output logic                     tx_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]  LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [12:0]  N_DEFAULT = 13'(CLK_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   level_reg, level_next;
    logic          full_reg, empty_reg, overflow_reg;

    state_t        state_reg;
    logic [12:0]   cnt_reg, n_reg, n_sel;
    logic [2:0]    bit_reg;
    logic [7:0]    shift_reg, head;
    logic          par_en_reg, par_bit_reg, tx_reg, busy_reg, done_reg;
    logic          push, pop, bit_end;

    assign push    = wr_en && !full_reg;
    assign bit_end = (cnt_reg == n_reg - 13'd1);
    // A pop happens when idle, or on the last stop cycle so frames run back to back.
    assign pop     = !empty_reg && ((state_reg == IDLE) || (state_reg == STOP && bit_end));
    assign head    = mem[rd_ptr_reg];

    always_comb begin
        n_sel = clk_per_bit;
        if (clk_per_bit == 13'd0)
            n_sel = N_DEFAULT;
        else if (clk_per_bit == 13'd1)
            n_sel = 13'd2;
        level_next = level_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (wr_en && full_reg)
                overflow_reg <= 1'b1;
            level_reg <= level_next;
            full_reg  <= (level_next == LVL_FULL);
            empty_reg <= (level_next == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            n_reg       <= 13'd2;
            bit_reg     <= '0;
            shift_reg   <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            // Registered pulse lands exactly on the final stop cycle.
            done_reg <= (state_reg == STOP) && (cnt_reg == n_reg - 13'd2);
            case (state_reg)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        state_reg <= DATA;
                        tx_reg    <= shift_reg[0];
                    end else begin
                        cnt_reg <= cnt_reg + 13'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (bit_reg == 3'd7) begin
                            state_reg <= par_en_reg ? PARITY : STOP;
                            tx_reg    <= par_en_reg ? par_bit_reg : 1'b1;
                        end else begin
                            bit_reg   <= bit_reg + 3'd1;
                            shift_reg <= shift_reg >> 1;
                            tx_reg    <= shift_reg[1];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 13'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        state_reg <= STOP;
                        tx_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 13'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        tx_reg    <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 13'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
            if (pop) begin
                state_reg   <= START;
                cnt_reg     <= '0;
                n_reg       <= n_sel;
                par_en_reg  <= parity_en;
                shift_reg   <= head;
                par_bit_reg <= ^head;
                bit_reg     <= '0;
                tx_reg      <= 1'b0;
                busy_reg    <= 1'b1;
            end
        end
    end

    assign full     = full_reg;
    assign empty    = empty_reg;
    assign level    = level_reg;
    assign overflow = overflow_reg;
    assign tx       = tx_reg;
    assign busy     = busy_reg;
    assign tx_done  = done_reg;
endmodule
